// File: rtl/dpm_scratchpad_pkg.sv
// dpm_scratchpad_pkg -- shared definitions for the DPM scratchpad.
//   WORD_W        data word width
//   SHARED_TEMPS  number of temps visible to both R and M sides (T0-7)
//   rsel_e        decoded R-side bank select
//   even_par()    even-parity bit over a data word (used when SPA_PARITY_EN)
package dpm_scratchpad_pkg;

    localparam int WORD_W       = 32;
    localparam int SHARED_TEMPS = 8;
    localparam int BANK_DEPTH   = 16;

    typedef enum logic [2:0] {
        RSEL_NONE  = 3'd0,
        RSEL_TMP   = 3'd1,
        RSEL_GPR   = 3'd2,
        RSEL_IPR   = 3'd3,
        RSEL_MULTI = 3'd4
    } rsel_e;

    // Parity bit that makes the total count of ones (data + bit) even.
    function automatic logic even_par(input logic [WORD_W-1:0] d);
        return ^d;
    endfunction

    // Active-low selects in; anything other than exactly one low is
    // NONE (all high) or MULTI (two or more low).
    function automatic rsel_e decode_rsel(input logic tmp_l, input logic gpr_l,
                                          input logic ipr_l);
        case ({tmp_l, gpr_l, ipr_l})
            3'b111:  return RSEL_NONE;
            3'b011:  return RSEL_TMP;
            3'b101:  return RSEL_GPR;
            3'b110:  return RSEL_IPR;
            default: return RSEL_MULTI;
        endcase
    endfunction

endpackage

// File: rtl/dpm_sp_bank.sv
// dpm_sp_bank -- one scratchpad bank, DEPTH words, NUM_PORTS write and
// NUM_PORTS combinational read ports (all ports share one write-data bus).
// Contents are never reset. With SPA_PARITY_EN defined each word carries an
// extra even-parity bit and every read port reports a parity mismatch.
//   clk      write clock
//   wr_en    per-port write enable
//   wr_addr  per-port write address
//   wr_data  write data (common to all ports)
//   rd_addr  per-port read address
//   rd_data  per-port read data
//   rd_perr  per-port parity mismatch (SPA_PARITY_EN only)
module dpm_sp_bank
    import dpm_scratchpad_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int NUM_PORTS = 1,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic [NUM_PORTS-1:0]              wr_en,
    input  logic [NUM_PORTS-1:0][AW-1:0]      wr_addr,
    input  logic [WORD_W-1:0]                 wr_data,
    input  logic [NUM_PORTS-1:0][AW-1:0]      rd_addr,
    output logic [NUM_PORTS-1:0][WORD_W-1:0]  rd_data
`ifdef SPA_PARITY_EN
    ,
    output logic [NUM_PORTS-1:0]              rd_perr
`endif
);

`ifdef SPA_PARITY_EN
    localparam int STORE_W = WORD_W + 1;
`else
    localparam int STORE_W = WORD_W;
`endif

    logic [STORE_W-1:0] mem_q [DEPTH];
    logic [STORE_W-1:0] wr_word_d;

    always_comb begin
`ifdef SPA_PARITY_EN
        wr_word_d = {even_par(wr_data), wr_data};
`else
        wr_word_d = wr_data;
`endif
    end

    // Ports hitting the same word carry the same data, so overlap is a
    // single effective write.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (wr_en[k]) mem_q[wr_addr[k]] <= wr_word_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            rd_data[k] = mem_q[rd_addr[k]][WORD_W-1:0];
`ifdef SPA_PARITY_EN
            rd_perr[k] = even_par(mem_q[rd_addr[k]][WORD_W-1:0]) != mem_q[rd_addr[k]][WORD_W];
`endif
        end
    end

endmodule

// File: rtl/dpm_scratchpad.sv
// dpm_scratchpad -- two-sided (R/M) microcode scratchpad.
// Banks: shared temps T0-7 (one 8-word bank, two ports), R-only temps 8-15,
// M-only temps 8-15, GPR 0-15, IPR 0-15. Read phase loads rbus_h/mbus_h on
// the edge; write phase writes wbus_h to every selected location.
// Optional feature macro: SPA_PARITY_EN (per-word even parity + par_err_h).
//   m_clk_l     clock (rising edge)
//   reset_l     async active-low reset of output/flag registers only
//   d_clk_en_h  cycle enable
//   phase_h     0 = read phase, 1 = write phase
//   rspa_h      R-side address;  rcs_tmp_l/rcs_gpr_l/rcs_ipr_l R selects
//   mspa_h      M-side address;  mcs_tmp_l M temp select
//   wbus_h      write data
//   err_clr_h   clears sticky error flags
//   rbus_h      registered R read data
//   mbus_h      registered M read data
//   cs_err_h    sticky: more than one R select low on an enabled cycle
//   par_err_h   sticky parity error (0 without SPA_PARITY_EN)
module dpm_scratchpad
    import dpm_scratchpad_pkg::*;
(
    input  logic              m_clk_l,
    input  logic              reset_l,
    input  logic              d_clk_en_h,
    input  logic              phase_h,
    input  logic [3:0]        rspa_h,
    input  logic [3:0]        mspa_h,
    input  logic              rcs_tmp_l,
    input  logic              rcs_gpr_l,
    input  logic              rcs_ipr_l,
    input  logic              mcs_tmp_l,
    input  logic [WORD_W-1:0] wbus_h,
    input  logic              err_clr_h,
    output logic [WORD_W-1:0] rbus_h,
    output logic [WORD_W-1:0] mbus_h,
    output logic              cs_err_h,
    output logic              par_err_h
);

    rsel_e rsel;
    logic  rd_ph, wr_ph, r_single, r_multi, r_wr, m_wr, r_hi, m_hi;

    assign rsel     = decode_rsel(rcs_tmp_l, rcs_gpr_l, rcs_ipr_l);
    assign rd_ph    = d_clk_en_h & ~phase_h;
    assign wr_ph    = d_clk_en_h &  phase_h;
    assign r_single = rsel inside {RSEL_TMP, RSEL_GPR, RSEL_IPR};
    assign r_multi  = (rsel == RSEL_MULTI);
    // A multi-select suppresses the R access; the M side is unaffected.
    assign r_wr     = wr_ph & r_single;
    assign m_wr     = wr_ph & ~mcs_tmp_l;
    // Temp addresses >= SHARED_TEMPS fall in the side-private banks.
    assign r_hi     = rspa_h >= 4'(SHARED_TEMPS);
    assign m_hi     = mspa_h >= 4'(SHARED_TEMPS);

    logic [1:0][WORD_W-1:0] shr_rd;
    logic [0:0][WORD_W-1:0] rtmp_rd, mtmp_rd, gpr_rd, ipr_rd;
`ifdef SPA_PARITY_EN
    logic [1:0] shr_perr;
    logic       rtmp_perr, mtmp_perr, gpr_perr, ipr_perr;
`endif

    // Port 0 = R side, port 1 = M side. Both may write distinct shared temps
    // in the same write phase, hence two write ports on this bank.
    dpm_sp_bank #(.DEPTH(SHARED_TEMPS), .NUM_PORTS(2)) u_shr (
        .clk     (m_clk_l),
        .wr_en   ({m_wr & ~m_hi, r_wr & (rsel == RSEL_TMP) & ~r_hi}),
        .wr_addr ({mspa_h[2:0], rspa_h[2:0]}),
        .wr_data (wbus_h),
        .rd_addr ({mspa_h[2:0], rspa_h[2:0]}),
        .rd_data (shr_rd)
`ifdef SPA_PARITY_EN
        , .rd_perr (shr_perr)
`endif
    );

    dpm_sp_bank #(.DEPTH(SHARED_TEMPS)) u_rtmp (
        .clk     (m_clk_l),
        .wr_en   (r_wr & (rsel == RSEL_TMP) & r_hi),
        .wr_addr (rspa_h[2:0]),
        .wr_data (wbus_h),
        .rd_addr (rspa_h[2:0]),
        .rd_data (rtmp_rd)
`ifdef SPA_PARITY_EN
        , .rd_perr (rtmp_perr)
`endif
    );

    dpm_sp_bank #(.DEPTH(SHARED_TEMPS)) u_mtmp (
        .clk     (m_clk_l),
        .wr_en   (m_wr & m_hi),
        .wr_addr (mspa_h[2:0]),
        .wr_data (wbus_h),
        .rd_addr (mspa_h[2:0]),
        .rd_data (mtmp_rd)
`ifdef SPA_PARITY_EN
        , .rd_perr (mtmp_perr)
`endif
    );

    dpm_sp_bank #(.DEPTH(BANK_DEPTH)) u_gpr (
        .clk     (m_clk_l),
        .wr_en   (r_wr & (rsel == RSEL_GPR)),
        .wr_addr (rspa_h),
        .wr_data (wbus_h),
        .rd_addr (rspa_h),
        .rd_data (gpr_rd)
`ifdef SPA_PARITY_EN
        , .rd_perr (gpr_perr)
`endif
    );

    dpm_sp_bank #(.DEPTH(BANK_DEPTH)) u_ipr (
        .clk     (m_clk_l),
        .wr_en   (r_wr & (rsel == RSEL_IPR)),
        .wr_addr (rspa_h),
        .wr_data (wbus_h),
        .rd_addr (rspa_h),
        .rd_data (ipr_rd)
`ifdef SPA_PARITY_EN
        , .rd_perr (ipr_perr)
`endif
    );

    logic [WORD_W-1:0] r_word, m_word;
    logic [WORD_W-1:0] rbus_d, rbus_q, mbus_d, mbus_q;
    logic              cs_err_d, cs_err_q;

    always_comb begin
        r_word = '0;
        case (rsel)
            RSEL_TMP: r_word = r_hi ? rtmp_rd[0] : shr_rd[0];
            RSEL_GPR: r_word = gpr_rd[0];
            RSEL_IPR: r_word = ipr_rd[0];
            default:  r_word = '0;
        endcase
        m_word = m_hi ? mtmp_rd[0] : shr_rd[1];

        rbus_d = rbus_q;
        if (rd_ph && r_single) rbus_d = r_word;
        mbus_d = mbus_q;
        if (rd_ph && !mcs_tmp_l) mbus_d = m_word;
        // A new error on the same edge as a clear wins.
        cs_err_d = (d_clk_en_h & r_multi) | (cs_err_q & ~err_clr_h);
    end

    always_ff @(posedge m_clk_l or negedge reset_l) begin
        if (!reset_l) begin
            rbus_q   <= '0;
            mbus_q   <= '0;
            cs_err_q <= 1'b0;
        end else begin
            rbus_q   <= rbus_d;
            mbus_q   <= mbus_d;
            cs_err_q <= cs_err_d;
        end
    end

    assign rbus_h   = rbus_q;
    assign mbus_h   = mbus_q;
    assign cs_err_h = cs_err_q;

`ifdef SPA_PARITY_EN
    logic r_perr, par_err_d, par_err_q;

    always_comb begin
        r_perr = 1'b0;
        case (rsel)
            RSEL_TMP: r_perr = r_hi ? rtmp_perr : shr_perr[0];
            RSEL_GPR: r_perr = gpr_perr;
            RSEL_IPR: r_perr = ipr_perr;
            default:  r_perr = 1'b0;
        endcase
        par_err_d = (rd_ph & ((r_single & r_perr) |
                              (~mcs_tmp_l & (m_hi ? mtmp_perr : shr_perr[1]))))
                  | (par_err_q & ~err_clr_h);
    end

    always_ff @(posedge m_clk_l or negedge reset_l) begin
        if (!reset_l) par_err_q <= 1'b0;
        else          par_err_q <= par_err_d;
    end

    assign par_err_h = par_err_q;
`else
    assign par_err_h = 1'b0;
`endif

endmodule

// File: tb/tb_dpm_scratchpad.sv
// tb_dpm_scratchpad -- scoreboard bench for dpm_scratchpad. A driver issues
// one cycle at a time, advances a behavioural model of the five banks and
// queues the expected outputs; a monitor on the falling edge compares them.
module tb_dpm_scratchpad;

    logic        m_clk_l, reset_l, d_clk_en_h, phase_h;
    logic [3:0]  rspa_h, mspa_h;
    logic        rcs_tmp_l, rcs_gpr_l, rcs_ipr_l, mcs_tmp_l, err_clr_h;
    logic [31:0] wbus_h, rbus_h, mbus_h;
    logic        cs_err_h, par_err_h;

    dpm_scratchpad dut (
        .m_clk_l(m_clk_l), .reset_l(reset_l), .d_clk_en_h(d_clk_en_h),
        .phase_h(phase_h), .rspa_h(rspa_h), .mspa_h(mspa_h),
        .rcs_tmp_l(rcs_tmp_l), .rcs_gpr_l(rcs_gpr_l), .rcs_ipr_l(rcs_ipr_l),
        .mcs_tmp_l(mcs_tmp_l), .wbus_h(wbus_h), .err_clr_h(err_clr_h),
        .rbus_h(rbus_h), .mbus_h(mbus_h), .cs_err_h(cs_err_h), .par_err_h(par_err_h)
    );

    initial begin
        m_clk_l = 1'b0;
        forever #5 m_clk_l = ~m_clk_l;
    end

    typedef struct {
        logic [31:0] r;
        logic [31:0] m;
        logic        cs;
        logic        par;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: plain arrays per storage region.
    logic [31:0] shr_m[8], rtmp_m[8], mtmp_m[8], gpr_m[16], ipr_m[16];
    logic [31:0] exp_r = '0, exp_m = '0;
    logic        exp_cs = 1'b0, exp_par = 1'b0;
    logic        ipr2_bad = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge m_clk_l) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("rbus_h", rbus_h, e.r);
            chk("mbus_h", mbus_h, e.m);
            chk("cs_err_h", 32'(cs_err_h), 32'(e.cs));
            chk("par_err_h", 32'(par_err_h), 32'(e.par));
        end
    end

    task automatic idle();
        d_clk_en_h = 1'b0; phase_h = 1'b0; err_clr_h = 1'b0;
        rcs_tmp_l = 1'b1; rcs_gpr_l = 1'b1; rcs_ipr_l = 1'b1; mcs_tmp_l = 1'b1;
        rspa_h = '0; mspa_h = '0; wbus_h = '0;
    endtask

    // One clock: rt/rg/ri/mt are the active-low selects.
    task automatic cyc(input logic en, input logic ph, input logic [3:0] ra,
                       input logic rt, input logic rg, input logic ri,
                       input logic [3:0] ma, input logic mt,
                       input logic [31:0] wd, input logic clr);
        int nsel;
        logic [31:0] rw, mw;
        logic par_set;
        exp_t e;
        @(negedge m_clk_l);
        #1;
        d_clk_en_h = en; phase_h = ph; rspa_h = ra; mspa_h = ma;
        rcs_tmp_l = rt; rcs_gpr_l = rg; rcs_ipr_l = ri; mcs_tmp_l = mt;
        wbus_h = wd; err_clr_h = clr;

        nsel = (rt ? 0 : 1) + (rg ? 0 : 1) + (ri ? 0 : 1);
        if (!rt)      rw = (ra < 8) ? shr_m[ra] : rtmp_m[ra - 8];
        else if (!rg) rw = gpr_m[ra];
        else          rw = ipr_m[ra];
        mw = (ma < 8) ? shr_m[ma] : mtmp_m[ma - 8];
        par_set = 1'b0;

        if (en && !ph) begin
            if (nsel == 1) begin
                exp_r = rw;
                if (!ri && ra == 2 && ipr2_bad) par_set = 1'b1;
            end
            if (!mt) exp_m = mw;
        end
        if (en && ph) begin
            if (nsel == 1) begin
                if (!rt) begin
                    if (ra < 8) shr_m[ra] = wd; else rtmp_m[ra - 8] = wd;
                end
                else if (!rg) gpr_m[ra] = wd;
                else begin
                    ipr_m[ra] = wd;
                    if (ra == 2) ipr2_bad = 1'b0;
                end
            end
            if (!mt) begin
                if (ma < 8) shr_m[ma] = wd; else mtmp_m[ma - 8] = wd;
            end
        end
        exp_cs  = (en && nsel >= 2) || (exp_cs && !clr);
        exp_par = par_set || (exp_par && !clr);

        e.r = exp_r; e.m = exp_m; e.cs = exp_cs; e.par = exp_par;
        sb_q.push_back(e);
        @(posedge m_clk_l);
    endtask

    initial begin
        logic [2:0] rs;
        idle();
        reset_l = 1'b1;
        #3 reset_l = 1'b0;
        #9;
        chk("reset rbus_h", rbus_h, 32'h0);
        chk("reset mbus_h", mbus_h, 32'h0);
        chk("reset cs_err_h", 32'(cs_err_h), 32'h0);
        chk("reset par_err_h", 32'(par_err_h), 32'h0);
        @(negedge m_clk_l);
        reset_l = 1'b1;

        // Fill every word so later reads are defined.
        for (int i = 0; i < 16; i++)
            cyc(1, 1, 4'(i), 0, 1, 1, 4'(i), 0, $urandom, 0);
        for (int i = 0; i < 16; i++)
            cyc(1, 1, 4'(i), 1, 0, 1, 4'(0), 1, $urandom, 0);
        for (int i = 0; i < 16; i++)
            cyc(1, 1, 4'(i), 1, 1, 0, 4'(0), 1, $urandom, 0);

        // R-side shared write seen by M side.
        cyc(1, 1, 4'd3, 0, 1, 1, 4'd0, 1, 32'h12345678, 0);
        cyc(1, 0, 4'd0, 1, 1, 1, 4'd3, 0, 32'h0, 0);
        // Private temps at address 9 are distinct.
        cyc(1, 1, 4'd9, 0, 1, 1, 4'd0, 1, 32'hAAAA0000, 0);
        cyc(1, 1, 4'd0, 1, 1, 1, 4'd9, 0, 32'h5555FFFF, 0);
        cyc(1, 0, 4'd9, 0, 1, 1, 4'd9, 0, 32'h0, 0);
        // Multi-select error, hold, then clear.
        cyc(1, 0, 4'd4, 1, 0, 0, 4'd1, 0, 32'h0, 0);
        cyc(0, 0, 4'd0, 1, 1, 1, 4'd0, 1, 32'h0, 1);
        cyc(1, 0, 4'd4, 1, 0, 1, 4'd1, 1, 32'h0, 0);
        // Multi-select in write phase suppresses R write; clear and error together.
        cyc(1, 1, 4'd4, 1, 0, 0, 4'd12, 0, 32'hCAFE0001, 1);
        cyc(1, 0, 4'd4, 1, 0, 1, 4'd12, 0, 32'h0, 1);
        // Disabled write must not land.
        cyc(1, 1, 4'd5, 1, 0, 1, 4'd0, 1, 32'h0BADF00D, 0);
        cyc(0, 1, 4'd5, 1, 0, 1, 4'd0, 1, 32'hDEADBEEF, 0);
        cyc(1, 0, 4'd5, 1, 0, 1, 4'd0, 1, 32'h0, 0);
        // Both sides write the same shared temp.
        cyc(1, 1, 4'd6, 0, 1, 1, 4'd6, 0, 32'h600D600D, 0);
        cyc(1, 0, 4'd6, 0, 1, 1, 4'd6, 0, 32'h0, 0);

        // Async reset between edges, contents preserved.
        cyc(1, 1, 4'd7, 1, 0, 1, 4'd0, 1, 32'hFFFFFFFF, 0);
        cyc(1, 0, 4'd7, 1, 0, 1, 4'd7, 0, 32'h0, 0);
        @(negedge m_clk_l);
        #1 idle();
        reset_l = 1'b0;
        #1;
        chk("async reset rbus_h", rbus_h, 32'h0);
        chk("async reset mbus_h", mbus_h, 32'h0);
        exp_r = '0; exp_m = '0; exp_cs = 1'b0; exp_par = 1'b0;
        #1 reset_l = 1'b1;
        cyc(1, 0, 4'd7, 1, 0, 1, 4'd0, 1, 32'h0, 0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 5))
                0:       rs = 3'b111;
                1, 5:    rs = 3'b011;
                2:       rs = 3'b101;
                3:       rs = 3'b110;
                default: rs = 3'(1 << $urandom_range(0, 2)) & 3'b111;
            endcase
            cyc(($urandom % 8) != 0, $urandom_range(0, 1) == 1,
                4'($urandom), rs[2], rs[1], rs[0],
                4'($urandom), ($urandom % 3) == 0,
                $urandom, ($urandom % 10) == 0);
        end

`ifdef SPA_PARITY_EN
        // Corrupt stored parity of IPR 2 and read it back.
        cyc(0, 0, 4'd0, 1, 1, 1, 4'd0, 1, 32'h0, 1);
        #1;
        dut.u_ipr.mem_q[2][32] = ~dut.u_ipr.mem_q[2][32];
        ipr2_bad = 1'b1;
        cyc(1, 0, 4'd2, 1, 1, 0, 4'd0, 1, 32'h0, 0);
        cyc(0, 0, 4'd0, 1, 1, 1, 4'd0, 1, 32'h0, 1);
`endif

        @(negedge m_clk_l);
        #1 idle();
        repeat (3) @(negedge m_clk_l);
        #1;
        chk("scoreboard drained", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dpm_scratchpad.md
DPM_SCRATCHPAD -- requirements
Module: dpm_scratchpad

Interface
REQ-001 m_clk_l  in  1  system clock; all state updates on its rising edge.
REQ-002 reset_l  in  1  reset; asynchronous, active-low.
REQ-003 d_clk_en_h  in  1  cycle enable; no state changes when low.
REQ-004 phase_h  in  1  0 = read phase, 1 = write phase.
REQ-005 rspa_h, mspa_h  in  4 each  R-side and M-side scratchpad addresses.
REQ-006 rcs_tmp_l, rcs_gpr_l, rcs_ipr_l, mcs_tmp_l  in  1 each  active-low bank selects.
REQ-007 wbus_h  in  32  write data.
REQ-008 err_clr_h  in  1  clears sticky error flags.
REQ-009 rbus_h, mbus_h  out  32 each  registered R and M read data.
REQ-010 cs_err_h  out  1  sticky: more than one R-side select low.
REQ-011 par_err_h  out  1  sticky parity error; tied 0 without SPA_PARITY_EN.

Function
REQ-012 Storage SHALL be: shared temps T0-7 (R addr 0-7 = M addr 0-7), R-only temps 8-15, M-only temps 8-15, GPR 0-15, IPR 0-15; 32 bits each.
REQ-013 R-side temp select with rspa_h<8 and M-side temp select with mspa_h<8 SHALL address the same shared word.
REQ-014 Read phase (phase_h=0, d_clk_en_h=1): on edge, rbus_h SHALL load the word selected by the single low R select at rspa_h; no R select low -> rbus_h holds.
REQ-015 Read phase: mbus_h SHALL load M temp at mspa_h if mcs_tmp_l low, else hold.
REQ-016 Read latency SHALL be one edge; rbus_h/mbus_h stable through following write phase.
REQ-017 Write phase (phase_h=1, d_clk_en_h=1): on edge, wbus_h SHALL be written to each selected location (R select at rspa_h; M temp at mspa_h).
REQ-018 Write phase SHALL NOT change rbus_h/mbus_h.
REQ-019 Both sides selecting the same shared temp in one write SHALL perform a single write (no conflict).
REQ-020 Two or more R selects low in either phase SHALL set cs_err_h, suppress the R-side access (no R write; rbus_h holds); M side proceeds.
REQ-021 Read of a location written in the previous write phase SHALL return the new value (write precedes next read edge; no bypass logic needed).
REQ-022 err_clr_h=1 on an edge SHALL clear cs_err_h and par_err_h; a simultaneous new error SHALL win (flag set).
REQ-023 d_clk_en_h=0 SHALL suppress reads, writes and flag setting; err_clr_h still acts.

Reset
REQ-024 reset_l low SHALL asynchronously clear rbus_h, mbus_h, cs_err_h, par_err_h to 0.
REQ-025 Array contents SHALL NOT be reset; reading an unwritten word is undefined (X in simulation).
REQ-026 Reset asserted mid-write SHALL leave the target word undefined; all other words unchanged.

Configuration
REQ-027 Macro SPA_PARITY_EN defined: each word stores a 33rd even-parity bit generated on write; every read checks it and a mismatch sets par_err_h (data still loaded).
REQ-028 SPA_PARITY_EN undefined: 32-bit words, no check, par_err_h constant 0.

Structure
REQ-029 Shared package SHALL hold bank-select encoding, word width (32), shared-temp boundary (8) and parity helper function.
REQ-030 One sub-module dpm_sp_bank (16-word, 1 write/1 read port, optional parity) SHALL be instantiated per bank; shared temps use one 8-word instance with two read ports.

Verification
REQ-031 Write phase rspa=3, rcs_tmp_l=0, wbus=0x12345678; read phase mspa=3, mcs_tmp_l=0 -> mbus_h=0x12345678.
REQ-032 Write R temp 9 = 0xAAAA0000 and M temp 9 = 0x5555FFFF; read both at 9 -> rbus_h=0xAAAA0000, mbus_h=0x5555FFFF.
REQ-033 Read with rcs_gpr_l=0 and rcs_ipr_l=0 -> cs_err_h=1, rbus_h unchanged; err_clr_h pulse -> cs_err_h=0.
REQ-034 Write GPR 5=0xDEADBEEF with d_clk_en_h=0; read GPR 5 -> prior value, not 0xDEADBEEF.
REQ-035 reset_l pulsed low between edges with rbus_h=0xFFFFFFFF -> rbus_h=0 immediately, array contents preserved on next read.
REQ-036 SPA_PARITY_EN: force-flip stored parity of IPR 2, read IPR 2 -> par_err_h=1 next edge, rbus_h loads data.
